// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared field widths, offsets, digit limits and time type for counter
`timescale 1ns/1ps
package counter_pkg;

    localparam int TIME_W = 20;

    localparam int W_SU = 4;
    localparam int W_ST = 3;
    localparam int W_MU = 4;
    localparam int W_MT = 3;
    localparam int W_HU = 4;
    localparam int W_HT = 2;

    localparam int OFF_SU = 0;
    localparam int OFF_ST = 4;
    localparam int OFF_MU = 7;
    localparam int OFF_MT = 11;
    localparam int OFF_HU = 14;
    localparam int OFF_HT = 18;

    localparam int MAX_UNITS   = 9;
    localparam int MAX_TENS    = 5;
    localparam int MAX_HT      = 2;
    localparam int MAX_HU_LAST = 3;

    typedef logic [TIME_W-1:0] time_t;

    function automatic time_t pack_time(
        input logic [W_HT-1:0] ht,
        input logic [W_HU-1:0] hu,
        input logic [W_MT-1:0] mt,
        input logic [W_MU-1:0] mu,
        input logic [W_ST-1:0] st,
        input logic [W_SU-1:0] su
    );
        time_t t;
        t = '0;
        t[OFF_HT +: W_HT] = ht;
        t[OFF_HU +: W_HU] = hu;
        t[OFF_MT +: W_MT] = mt;
        t[OFF_MU +: W_MU] = mu;
        t[OFF_ST +: W_ST] = st;
        t[OFF_SU +: W_SU] = su;
        return t;
    endfunction

endpackage

// File: rtl/counter_bcd_digit.sv
// rtl/counter_bcd_digit.sv - one wrapping BCD digit with increment, clear and carry-out
`timescale 1ns/1ps
module bcd_digit #(
    parameter int W   = 4,
    parameter int MAX = 9
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(MAX);

    assign carry = inc && (value == LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= (value == LAST) ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/counter.sv
// rtl/counter.sv - 24-hour BCD time-of-day counter; optional day_pulse under COUNTER_DAY_PULSE_EN
`timescale 1ns/1ps
module counter
    import counter_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rstn,
    output logic [TIME_W-1:0] out_time
`ifdef COUNTER_DAY_PULSE_EN
    ,
    output logic              day_pulse
`endif
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    logic [W_SU-1:0] su;
    logic [W_ST-1:0] st;
    logic [W_MU-1:0] mu;
    logic [W_MT-1:0] mt;
    logic [W_HU-1:0] hu;
    logic [W_HT-1:0] ht;
    logic            su_c, st_c, mu_c, mt_c, hu_c, ht_c;
    logic            at_last;
    logic            day_wrap;

    // Hours wrap at 23, not at the natural 29/99 digit limits, so both hour
    // digits are cleared from here on the final tick of the day.
    assign at_last = (ht == W_HT'(MAX_HT)) && (hu == W_HU'(MAX_HU_LAST)) &&
                     (mt == W_MT'(MAX_TENS)) && (mu == W_MU'(MAX_UNITS)) &&
                     (st == W_ST'(MAX_TENS)) && (su == W_SU'(MAX_UNITS));
    assign day_wrap = (tick && at_last) || ht_c;

    bcd_digit #(.W(W_SU), .MAX(MAX_UNITS)) u_su (
        .clk(clk), .rstn(rstn), .inc(tick), .clr(1'b0), .value(su), .carry(su_c)
    );
    bcd_digit #(.W(W_ST), .MAX(MAX_TENS)) u_st (
        .clk(clk), .rstn(rstn), .inc(su_c), .clr(1'b0), .value(st), .carry(st_c)
    );
    bcd_digit #(.W(W_MU), .MAX(MAX_UNITS)) u_mu (
        .clk(clk), .rstn(rstn), .inc(st_c), .clr(1'b0), .value(mu), .carry(mu_c)
    );
    bcd_digit #(.W(W_MT), .MAX(MAX_TENS)) u_mt (
        .clk(clk), .rstn(rstn), .inc(mu_c), .clr(1'b0), .value(mt), .carry(mt_c)
    );
    bcd_digit #(.W(W_HU), .MAX(MAX_UNITS)) u_hu (
        .clk(clk), .rstn(rstn), .inc(mt_c), .clr(day_wrap), .value(hu), .carry(hu_c)
    );
    bcd_digit #(.W(W_HT), .MAX(MAX_HT)) u_ht (
        .clk(clk), .rstn(rstn), .inc(hu_c), .clr(day_wrap), .value(ht), .carry(ht_c)
    );

    assign out_time = pack_time(ht, hu, mt, mu, st, su);

`ifdef COUNTER_DAY_PULSE_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            day_pulse <= 1'b0;
        end else begin
            day_pulse <= day_wrap;
        end
    end
`endif

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - directed self-checking bench for counter (TICK_DIV=1 and TICK_DIV=4)
`timescale 1ns/1ps
module tb_counter;

    logic        clk;
    logic        rstn1;
    logic        rstn4;
    logic [19:0] time1;
    logic [19:0] time4;
    int          n_cmp;
    int          n_err;
    int          bad_bcd;
    int          bad_model;
`ifdef COUNTER_DAY_PULSE_EN
    logic        dp1;
    logic        dp4;
`endif

    counter #(.TICK_DIV(1)) dut1 (
        .clk      (clk),
        .rstn     (rstn1),
        .out_time (time1)
`ifdef COUNTER_DAY_PULSE_EN
        ,
        .day_pulse(dp1)
`endif
    );

    counter #(.TICK_DIV(4)) dut4 (
        .clk      (clk),
        .rstn     (rstn4),
        .out_time (time4)
`ifdef COUNTER_DAY_PULSE_EN
        ,
        .day_pulse(dp4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] hms(input int h, input int m, input int s);
        logic [1:0] ht;
        logic [3:0] hu;
        logic [2:0] mt;
        logic [3:0] mu;
        logic [2:0] st;
        logic [3:0] su;
        ht = 2'(h / 10);
        hu = 4'(h % 10);
        mt = 3'(m / 10);
        mu = 4'(m % 10);
        st = 3'(s / 10);
        su = 4'(s % 10);
        return {ht, hu, mt, mu, st, su};
    endfunction

    function automatic logic [19:0] from_secs(input int n);
        int t;
        t = n % 86400;
        return hms(t / 3600, (t / 60) % 60, t % 60);
    endfunction

    function automatic bit legal(input logic [19:0] t);
        return (t[3:0] <= 4'd9) && (t[6:4] <= 3'd5) && (t[10:7] <= 4'd9) &&
               (t[13:11] <= 3'd5) && (t[17:14] <= 4'd9) && (t[19:18] <= 2'd2) &&
               !((t[19:18] == 2'd2) && (t[17:14] > 4'd3));
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        bad_bcd = 0;
        bad_model = 0;
        rstn1 = 1'b0;
        rstn4 = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("reset_t1", 32'(time1), 32'h0);
        check_eq("reset_t4", 32'(time4), 32'h0);
`ifdef COUNTER_DAY_PULSE_EN
        check_eq("reset_dp1", 32'(dp1), 32'h0);
`endif

        // TICK_DIV=4: first tick on the 4th edge after release
        rstn4 = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("div4_e3", 32'(time4), 32'(hms(0, 0, 0)));
        @(negedge clk);
        check_eq("div4_e4", 32'(time4), 32'(hms(0, 0, 1)));
        @(negedge clk);
        @(posedge clk);
        #1 rstn4 = 1'b0;
        #1 check_eq("div4_async_rst", 32'(time4), 32'h0);
        @(negedge clk);
        rstn4 = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("div4_rel_e3", 32'(time4), 32'(hms(0, 0, 0)));
        @(negedge clk);
        check_eq("div4_rel_e4", 32'(time4), 32'(hms(0, 0, 1)));
        repeat (8) @(negedge clk);
        check_eq("div4_rel_e12", 32'(time4), 32'(hms(0, 0, 3)));

        // 0.5 ns reset glitch in the clock-low phase
        #1 rstn4 = 1'b0;
        #0.2 check_eq("glitch_during", 32'(time4), 32'h0);
        #0.3 rstn4 = 1'b1;
        #0.2 check_eq("glitch_after", 32'(time4), 32'h0);
        repeat (3) @(negedge clk);
        check_eq("glitch_presc_e3", 32'(time4), 32'(hms(0, 0, 0)));
        @(negedge clk);
        check_eq("glitch_presc_e4", 32'(time4), 32'(hms(0, 0, 1)));
        rstn4 = 1'b0;

        // TICK_DIV=1: run one full day plus a few seconds
        check_eq("div1_held", 32'(time1), 32'h0);
        rstn1 = 1'b1;
        for (int e = 1; e <= 86402; e++) begin
            @(negedge clk);
            if (!legal(time1)) bad_bcd++;
            if (time1 !== from_secs(e)) bad_model++;
            case (e)
                59:    check_eq("e59",    32'(time1), 32'(hms(0, 0, 59)));
                60:    check_eq("e60",    32'(time1), 32'(hms(0, 1, 0)));
                3599:  check_eq("e3599",  32'(time1), 32'(hms(0, 59, 59)));
                3600:  check_eq("e3600",  32'(time1), 32'(hms(1, 0, 0)));
                36000: check_eq("e36000", 32'(time1), 32'(hms(10, 0, 0)));
                86399: begin
                    check_eq("e86399", 32'(time1), 32'(hms(23, 59, 59)));
`ifdef COUNTER_DAY_PULSE_EN
                    check_eq("dp_before", 32'(dp1), 32'h0);
`endif
                end
                86400: begin
                    check_eq("e86400_wrap", 32'(time1), 32'(hms(0, 0, 0)));
`ifdef COUNTER_DAY_PULSE_EN
                    check_eq("dp_wrap", 32'(dp1), 32'h1);
`endif
                end
                86401: begin
                    check_eq("e86401", 32'(time1), 32'(hms(0, 0, 1)));
`ifdef COUNTER_DAY_PULSE_EN
                    check_eq("dp_after", 32'(dp1), 32'h0);
`endif
                end
                default: ;
            endcase
        end
        check_eq("bcd_legal_samples", 32'(bad_bcd), 32'h0);
        check_eq("model_samples", 32'(bad_model), 32'h0);

        #2 rstn1 = 1'b0;
        #1 check_eq("div1_final_rst", 32'(time1), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter: TICK_DIV, default 1, number of clk cycles per one-second advance (legal range 1..2^24).
REQ-002 Port: clk  input  1  single rising-edge clock for all state.
REQ-003 Port: rstn  input  1  reset; asynchronous and active-low.
REQ-004 Port: out_time  output  20  packed BCD time of day, registered.
REQ-005 out_time field map SHALL be: [19:18] hours tens (0..2), [17:14] hours units (0..9), [13:11] minutes tens (0..5), [10:7] minutes units (0..9), [6:4] seconds tens (0..5), [3:0] seconds units (0..9).

Function
REQ-006 The block SHALL be a free-running 24-hour time-of-day counter with a range of 00:00:00..23:59:59.
REQ-007 A tick SHALL occur on every TICK_DIV-th rising clk edge after reset release; with TICK_DIV=1, every edge is a tick.
REQ-008 On a tick, seconds units SHALL increment by 1; on 9, it SHALL wrap to 0 and carry to seconds tens.
REQ-009 On a carry into seconds tens at 5, the field SHALL wrap to 0 and carry to minutes units; minutes units and tens SHALL follow the same 9/5 rules, carrying into hours.
REQ-010 Hours SHALL count 00..23; at 23:59:59 a tick SHALL produce 00:00:00 on the same edge, with no intermediate values such as 24:00:00.
REQ-011 All fields SHALL update on the same edge, with no combinational path from any input to out_time.
REQ-012 out_time SHALL never hold a non-BCD or out-of-range digit.
REQ-013 The prescaler counter SHALL be ceil(log2(TICK_DIV)) bits wide (minimum 1) and SHALL wrap at TICK_DIV-1.

Reset
REQ-014 When rstn is low, out_time SHALL be 20'h00000 (00:00:00) and the prescaler SHALL be 0, without waiting for a clock edge.
REQ-015 Reset asserted mid-count SHALL clear state immediately; after release, the first tick SHALL occur on the TICK_DIV-th rising edge.
REQ-016 Release of rstn SHALL be sampled so that no tick occurs on an edge where rstn is low.

Configuration
REQ-017 Macro COUNTER_DAY_PULSE_EN SHALL be the only compile-time option.
REQ-018 With COUNTER_DAY_PULSE_EN defined, the block SHALL add output day_pulse (1 bit, registered), asserted for exactly one clk cycle coincident with out_time becoming 00:00:00 via wrap (not via reset), and 0 during reset.
REQ-019 Without COUNTER_DAY_PULSE_EN, the day_pulse port and its logic SHALL be absent, with behaviour otherwise identical.

Structure
REQ-020 Shared package counter_pkg SHALL hold: field widths (2,4,3,4,3,4), field bit offsets, digit limits (9,5,2,3), and the 20-bit time typedef.
REQ-021 A sub-module bcd_digit (parameterised max value and width; inputs inc and clear-to-zero; outputs value and carry) SHALL be instantiated six times.
REQ-022 Hours-tens/units SHALL use an extra 23-wrap override in the top level rather than in bcd_digit.

Verification
REQ-023 Pulse rstn low for 0.5 ns at any time -> out_time = 20'h00000 immediately, regardless of clk.
REQ-024 TICK_DIV=1, 59 edges after reset -> 00:00:59; next edge -> 00:01:00.
REQ-025 TICK_DIV=1, 3599 edges -> 00:59:59; next -> 01:00:00; after 36000 edges total -> 10:00:00.
REQ-026 TICK_DIV=1, 86399 edges -> 23:59:59; next -> 00:00:00, with day_pulse high for that one cycle when COUNTER_DAY_PULSE_EN is set; run 1,297,500 edges and check every sample for a legal BCD time.
REQ-027 TICK_DIV=4: 3 edges -> 00:00:00, 4th edge -> 00:00:01; assert rstn at edge 6 -> 00:00:00; 4 edges after release -> 00:00:01.
